// File: rtl/qsn_pipe_pkg.sv
// Shared configuration for the quasi-cyclic shift network: lane count, lane width,
// sideband widths, the LLR lane types and a lane extraction helper.
package qsn_pipe_pkg;

    localparam int LiftingFactor = 16;
    localparam int DataWidth     = 6;
    localparam int TagWidth      = 4;
    localparam int ShiftWidth    = $clog2(LiftingFactor);
    localparam int ZWidth        = $clog2(LiftingFactor + 1);
    localparam int VecWidth      = LiftingFactor * DataWidth;

    typedef logic [DataWidth-1:0] llr_t;
    typedef llr_t qsn_vec_t [LiftingFactor];

    // Lane idx of a flat lane vector; lane 0 sits in the least significant bits.
    function automatic llr_t lane_of(input logic [VecWidth-1:0] vec, input int idx);
        return vec[idx*DataWidth +: DataWidth];
    endfunction

endpackage

// File: rtl/qsn_barrel_shift.sv
// Combinational logarithmic lane shifter with zero fill. Shifts a flat lane vector
// by 'amount' whole lanes: Left=0 moves lane i+n down to lane i, Left=1 moves lane
// i-n up to lane i. One mux stage per amount bit.
module qsn_barrel_shift
    import qsn_pipe_pkg::*;
#(
    parameter bit Left        = 1'b0,
    parameter int AmountWidth = ShiftWidth
) (
    input  logic [VecWidth-1:0]    in_data,
    input  logic [AmountWidth-1:0] amount,
    output logic [VecWidth-1:0]    out_data
);

    logic [VecWidth-1:0] stage [AmountWidth+1];

    assign stage[0] = in_data;

    // Stage k conditionally moves the vector by 2^k lanes; shifting past the end yields zeros.
    for (genvar k = 0; k < AmountWidth; k++) begin : g_stage
        localparam int BitShift = DataWidth * (1 << k);
        if (Left) begin : g_left
            assign stage[k+1] = amount[k] ? (stage[k] << BitShift) : stage[k];
        end else begin : g_right
            assign stage[k+1] = amount[k] ? (stage[k] >> BitShift) : stage[k];
        end
    end

    assign out_data = stage[AmountWidth];

endmodule

// File: rtl/qsn_pipe.sv
// Three-stage valid/ready quasi-cyclic shift network. Rotates the first z lanes by s
// (forward, or inverse via s_eff = z - s), zeroes lanes >= z, and flags beats whose
// z/s are out of range. Each stage collapses bubbles independently.
module qsn_pipe
    import qsn_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [VecWidth-1:0]   i_data,
    input  logic [ShiftWidth-1:0] i_shift,
    input  logic [ZWidth-1:0]     i_z,
    input  logic                  i_inv,
    input  logic [TagWidth-1:0]   i_tag,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [VecWidth-1:0]   o_data,
    output logic [TagWidth-1:0]   o_tag,
    output logic                  o_err
);

    // Stage S0 state
    logic                     s0_valid;
    logic [VecWidth-1:0]      s0_data;
    logic [ShiftWidth-1:0]    s0_seff;
    logic [ZWidth-1:0]        s0_z;
    logic                     s0_err;
    logic [LiftingFactor-1:0] s0_mask;
    logic [TagWidth-1:0]      s0_tag;

    // Stage S1 state
    logic                     s1_valid;
    logic [VecWidth-1:0]      s1_left;
    logic [VecWidth-1:0]      s1_right;
    logic [ShiftWidth-1:0]    s1_seff;
    logic [ZWidth-1:0]        s1_z;
    logic                     s1_err;
    logic [LiftingFactor-1:0] s1_mask;
    logic [TagWidth-1:0]      s1_tag;

    // Stage S2 state, which is also the output register
    logic                     s2_valid;
    logic [VecWidth-1:0]      s2_data;
    logic [TagWidth-1:0]      s2_tag;
    logic                     s2_err;

    logic                     ready0;
    logic                     ready1;
    logic                     ready2;

    logic [ShiftWidth-1:0]    in_seff;
    logic                     in_err;
    logic [LiftingFactor-1:0] in_mask;
    logic [ZWidth-1:0]        right_amt;
    logic [VecWidth-1:0]      shift_left_lanes;
    logic [VecWidth-1:0]      shift_right_lanes;
    logic [VecWidth-1:0]      merged;

    // A stage can take a new beat when it is empty or its successor is taking its beat.
    assign ready2  = ~s2_valid | o_ready;
    assign ready1  = ~s1_valid | ready2;
    assign ready0  = ~s0_valid | ready1;
    assign i_ready = ready0;

    // Range check on the beat parameters: z must be 1..N and s must be below z.
    always_comb begin
        in_err = 1'b0;
        if ((i_z == '0) || (i_z > ZWidth'(LiftingFactor)) || (ZWidth'(i_shift) >= i_z)) begin
            in_err = 1'b1;
        end
    end

    // Inverse rotation by s is the forward rotation by z-s (s=0 stays 0).
    always_comb begin
        in_seff = i_shift;
        if (i_inv && (i_shift != '0)) begin
            in_seff = ShiftWidth'(i_z - ZWidth'(i_shift));
        end
    end

    // Lanes below z are active, the rest are forced to zero at the merge.
    always_comb begin
        in_mask = '0;
        for (int i = 0; i < LiftingFactor; i++) begin
            in_mask[i] = (ZWidth'(i) < i_z);
        end
    end

    // S0: capture the accepted beat together with its derived shift, mask and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_seff  <= '0;
            s0_z     <= '0;
            s0_err   <= 1'b0;
            s0_mask  <= '0;
            s0_tag   <= '0;
        end else if (ready0) begin
            s0_valid <= i_valid;
            if (i_valid) begin
                s0_data <= i_data;
                s0_seff <= in_seff;
                s0_z    <= i_z;
                s0_err  <= in_err;
                s0_mask <= in_mask;
                s0_tag  <= i_tag;
            end
        end
    end

    // The wrap-around part of the rotation comes from shifting up by z - s_eff lanes.
    assign right_amt = s0_z - ZWidth'(s0_seff);

    qsn_barrel_shift #(
        .Left        (1'b0),
        .AmountWidth (ShiftWidth)
    ) u_shift_down (
        .in_data  (s0_data),
        .amount   (s0_seff),
        .out_data (shift_left_lanes)
    );

    qsn_barrel_shift #(
        .Left        (1'b1),
        .AmountWidth (ZWidth)
    ) u_shift_up (
        .in_data  (s0_data),
        .amount   (right_amt),
        .out_data (shift_right_lanes)
    );

    // S1: register both partial rotations so the merge sees only a 2:1 select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_left  <= '0;
            s1_right <= '0;
            s1_seff  <= '0;
            s1_z     <= '0;
            s1_err   <= 1'b0;
            s1_mask  <= '0;
            s1_tag   <= '0;
        end else if (ready1) begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_left  <= shift_left_lanes;
                s1_right <= shift_right_lanes;
                s1_seff  <= s0_seff;
                s1_z     <= s0_z;
                s1_err   <= s0_err;
                s1_mask  <= s0_mask;
                s1_tag   <= s0_tag;
            end
        end
    end

    // Lane i reads the down-shifted copy until its source index wraps past z.
    always_comb begin
        merged = '0;
        for (int i = 0; i < LiftingFactor; i++) begin
            if (!s1_err && s1_mask[i]) begin
                if ((i + int'(s1_seff)) < int'(s1_z)) begin
                    merged[i*DataWidth +: DataWidth] = lane_of(s1_left, i);
                end else begin
                    merged[i*DataWidth +: DataWidth] = lane_of(s1_right, i);
                end
            end
        end
    end

    // S2: output register; holds its beat while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
        end else if (ready2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= merged;
                s2_tag  <= s1_tag;
                s2_err  <= s1_err;
            end
        end
    end

    assign o_valid = s2_valid;
    assign o_data  = s2_data;
    assign o_tag   = s2_tag;
    assign o_err   = s2_err;

endmodule

// File: tb/tb_qsn_pipe.sv
// Self-checking bench for qsn_pipe. A queue-based model predicts every output beat
// from the rotation rules; directed beats pin literal results, then backpressure,
// randomized traffic and a mid-stream reset are exercised.
module tb_qsn_pipe;
    import qsn_pipe_pkg::*;

    localparam int N  = LiftingFactor;
    localparam int DW = DataWidth;
    localparam int VW = VecWidth;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_valid = 1'b0;
    logic                  i_ready;
    logic [VW-1:0]         i_data = '0;
    logic [ShiftWidth-1:0] i_shift = '0;
    logic [ZWidth-1:0]     i_z = '0;
    logic                  i_inv = 1'b0;
    logic [TagWidth-1:0]   i_tag = '0;
    logic                  o_valid;
    logic                  o_ready = 1'b1;
    logic [VW-1:0]         o_data;
    logic [TagWidth-1:0]   o_tag;
    logic                  o_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [VW-1:0]       data;
        logic                err;
        logic [TagWidth-1:0] tag;
    } beat_t;

    beat_t               expq[$];
    logic [TagWidth-1:0] seenTags[$];
    bit                  recordTags = 0;
    bit                  sawIreadyLow = 0;
    logic                heldValid = 1'b0;
    logic [VW-1:0]       heldData;
    logic [TagWidth-1:0] heldTag;
    logic                heldErr;

    always #5 clk = ~clk;

    qsn_pipe dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_shift (i_shift),
        .i_z     (i_z),
        .i_inv   (i_inv),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_tag   (o_tag),
        .o_err   (o_err)
    );

    // Expected result of one beat, straight from the modular-index rotation rules.
    function automatic beat_t modelBeat(logic [VW-1:0] din, int s, int z, bit inv, logic [TagWidth-1:0] tag);
        beat_t b;
        int src;
        b.data = '0;
        b.tag  = tag;
        b.err  = (z == 0) || (z > N) || (s >= z);
        if (!b.err) begin
            for (int i = 0; i < z; i++) begin
                src = inv ? ((i - s + z) % z) : ((i + s) % z);
                b.data[i*DW +: DW] = din[src*DW +: DW];
            end
        end
        return b;
    endfunction

    function automatic logic [VW-1:0] mkVec(int vals[16]);
        logic [VW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(vals[i]);
        return v;
    endfunction

    function automatic logic [VW-1:0] rampVec();
        logic [VW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(i);
        return v;
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic checkVal(string name, logic [VW-1:0] act, logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic failNow(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Compare process: every cycle, check readiness, held outputs and delivered beats against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            heldValid = 1'b0;
        end else begin
            checkVal("i_ready", VW'(i_ready), VW'((expq.size() == 3 && !o_ready) ? 0 : 1));
            if (!i_ready) sawIreadyLow = 1;
            if (heldValid) begin
                checkVal("hold_valid", VW'(o_valid), VW'(1));
                checkVal("hold_data", o_data, heldData);
                checkVal("hold_tag", VW'(o_tag), VW'(heldTag));
                checkVal("hold_err", VW'(o_err), VW'(heldErr));
            end
            if (o_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_out: got tag %0d, expected no beat", o_tag);
                end else begin
                    checkVal("model_data", o_data, expq[0].data);
                    checkVal("model_err", VW'(o_err), VW'(expq[0].err));
                    checkVal("model_tag", VW'(o_tag), VW'(expq[0].tag));
                    if (o_ready) begin
                        if (recordTags) seenTags.push_back(o_tag);
                        void'(expq.pop_front());
                    end
                end
            end
            heldValid = o_valid && !o_ready;
            heldData  = o_data;
            heldTag   = o_tag;
            heldErr   = o_err;
            if (i_valid && i_ready)
                expq.push_back(modelBeat(i_data, int'(i_shift), int'(i_z), i_inv, i_tag));
        end
    end

    // Present one beat after the next rising edge and hold it until accepted.
    task automatic applyStimulus(logic [VW-1:0] data, int s, int z, bit inv, logic [TagWidth-1:0] tag);
        int n = 0;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_data  = data;
        i_shift = ShiftWidth'(s);
        i_z     = ZWidth'(z);
        i_inv   = inv;
        i_tag   = tag;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ready && n < 200);
        if (!i_ready) failNow("accept");
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Wait for the next output beat and compare it with literal expectations.
    task automatic checkOutput(string name, logic [VW-1:0] expData, logic expErr, logic [TagWidth-1:0] expTag, int expLat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 50);
        if (!o_valid) begin
            failNow(name);
        end else begin
            if (expLat > 0) checkVal({name, "_latency"}, VW'(n), VW'(expLat));
            checkVal({name, "_data"}, o_data, expData);
            checkVal({name, "_err"}, VW'(o_err), VW'(expErr));
            checkVal({name, "_tag"}, VW'(o_tag), VW'(expTag));
        end
    endtask

    task automatic drain();
        int n = 0;
        o_ready = 1'b1;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) failNow("drain");
    endtask

    // Main sequence: reset, directed literals, backpressure, random traffic, mid-stream reset.
    initial begin
        int lit[16];
        logic [VW-1:0] v;
        bit doneA;

        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_valid", VW'(o_valid), VW'(0));
        checkVal("reset_data", o_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("post_reset_ready", VW'(i_ready), VW'(1));
        checkVal("post_reset_valid", VW'(o_valid), VW'(0));

        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'((i + 3) % 16);
        applyStimulus(rampVec(), 3, 16, 0, 4'd1);
        idle();
        checkOutput("z16_s3_fwd", v, 1'b0, 4'd1, 3);

        lit = '{2, 3, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(rampVec(), 2, 5, 0, 4'd2);
        idle();
        checkOutput("z5_s2_fwd", mkVec(lit), 1'b0, 4'd2, 3);

        lit = '{3, 4, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(rampVec(), 2, 5, 1, 4'd3);
        idle();
        checkOutput("z5_s2_inv", mkVec(lit), 1'b0, 4'd3, 3);

        applyStimulus(rampVec() | VW'(6'd0), 0, 1, 0, 4'd4);
        idle();
        checkOutput("z1_s0", '0, 1'b0, 4'd4, 3);

        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'((i + 1) % 16);
        applyStimulus(rampVec(), 15, 16, 1, 4'd5);
        idle();
        checkOutput("z16_s15_inv", v, 1'b0, 4'd5, 3);

        lit = '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(rampVec(), 0, 7, 1, 4'd6);
        idle();
        checkOutput("z7_s0_ident", mkVec(lit), 1'b0, 4'd6, 3);

        applyStimulus(rampVec(), 5, 5, 0, 4'd9);
        idle();
        checkOutput("illegal_s_eq_z", '0, 1'b1, 4'd9, 3);

        applyStimulus(rampVec(), 0, 0, 0, 4'd10);
        idle();
        checkOutput("illegal_z0", '0, 1'b1, 4'd10, 3);

        applyStimulus(rampVec(), 1, 17, 0, 4'd11);
        idle();
        checkOutput("illegal_z17", '0, 1'b1, 4'd11, 3);
        drain();

        $display("[TB] backpressure phase");
        seenTags.delete();
        recordTags = 1;
        sawIreadyLow = 0;
        doneA = 0;
        fork
            begin
                int z;
                for (int t = 0; t < 8; t++) begin
                    z = $urandom_range(1, 16);
                    applyStimulus(randVec(), $urandom_range(0, z - 1), z, bit'($urandom_range(0, 1)), TagWidth'(t));
                end
                idle();
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    @(posedge clk);
                    #2;
                    o_ready = !(c >= 4 && c <= 9);
                end
            end
        join
        drain();
        recordTags = 0;
        checkVal("bp_ready_low", VW'(sawIreadyLow), VW'(1));
        checkVal("bp_tag_count", VW'(seenTags.size()), VW'(8));
        for (int t = 0; t < 8; t++) begin
            if (t < seenTags.size()) checkVal("bp_tag_order", VW'(seenTags[t]), VW'(t));
        end

        $display("[TB] random phase");
        doneA = 0;
        fork
            begin
                int z;
                int s;
                for (int b = 0; b < 400; b++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        z = $urandom_range(0, 31);
                        s = $urandom_range(0, 15);
                    end else begin
                        z = $urandom_range(1, 16);
                        s = $urandom_range(0, z - 1);
                    end
                    applyStimulus(randVec(), s, z, bit'($urandom_range(0, 1)), TagWidth'($urandom));
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
                doneA = 1;
            end
            begin
                while (!doneA) begin
                    @(posedge clk);
                    #2;
                    o_ready = ($urandom_range(0, 3) != 0);
                end
                o_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset phase");
        applyStimulus(randVec(), 1, 8, 0, 4'd12);
        applyStimulus(randVec(), 2, 8, 1, 4'd13);
        idle();
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!o_valid && n < 20);
            if (!o_valid) failNow("rst_inflight");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("rst_async_valid", VW'(o_valid), VW'(0));
        checkVal("rst_async_data", o_data, '0);
        checkVal("rst_async_tag", VW'(o_tag), VW'(0));
        checkVal("rst_async_err", VW'(o_err), VW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkVal("rst_no_stale", VW'(o_valid), VW'(0));
        end
        lit = '{4, 5, 6, 7, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(rampVec(), 4, 8, 0, 4'd14);
        idle();
        checkOutput("rst_first_beat", mkVec(lit), 1'b0, 4'd14, 3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
